// File: rtl/counter_arbiter_pkg.sv
// Shared types for the counter arbiter slice.
//   op_t    : operation a requester asks of the shared counter
//   state_t : transaction sequencer states (one transaction per 3 cycles)
//   OP_W    : width of one requester's op field
package counter_arbiter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INC   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

endpackage

// File: rtl/counter_arbiter_if.sv
// Client-side bus of the counter arbiter.
//   req      : per-requester request, held until ack
//   req_op   : op per requester, slice i = [2i+1:2i]
//   req_data : load data per requester, slice i = [WIDTH*i +: WIDTH]
//   ack      : one-cycle one-hot completion pulse
//   rsp_cnt  : count after the op, valid with ack
//   rsp_ovf  : wrap/saturation flag, valid with ack
//   busy     : arbiter is mid-transaction
// master = client side, slave = arbiter side.
interface counter_arbiter_if
  import counter_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);

  logic [N_REQ-1:0]       req;
  logic [OP_W*N_REQ-1:0]  req_op;
  logic [WIDTH*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rsp_cnt;
  logic                   rsp_ovf;
  logic                   busy;

  modport master (
    output req, req_op, req_data,
    input  ack, rsp_cnt, rsp_ovf, busy
  );

  modport slave (
    input  req, req_op, req_data,
    output ack, rsp_cnt, rsp_ovf, busy
  );

endinterface

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index with highest priority this round (register lives in the parent)
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted requester
//   any_req : at least one request pending
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any_req
);

  int idx;

  // Scan from the farthest offset down to the pointer itself, so the last
  // hit written is the requester closest to the pointer in wrap order.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/counter_arbiter.sv
// Shares one loadable up-counter between N_REQ requesters.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : client request/response bus (slave side)
//   cnt_inc   : counter increment strobe (ISSUE only)
//   cnt_load  : counter load strobe (ISSUE only)
//   cnt_din   : counter load data
//   cnt_value : current counter output
// Each transaction is IDLE (arbitrate, latch) -> ISSUE (drive counter)
// -> RESP (ack winner with post-operation count).
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  counter_arbiter_if.slave bus,
  output logic             cnt_inc,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_din,
  input  logic [WIDTH-1:0] cnt_value
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit SAT   = (SATURATE != 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               ovf_q, ovf_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_req;
  logic [OP_W-1:0]    sel_op;
  logic [WIDTH-1:0]   sel_data;
  logic               cnt_max;
  logic [N_REQ-1:0]   ack;
  logic [WIDTH-1:0]   rsp_cnt;
  logic               rsp_ovf;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // AND-OR mux of the winner's op and data using the one-hot grant.
  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_op   = sel_op   | bus.req_op[OP_W*i +: OP_W];
        sel_data = sel_data | bus.req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  assign cnt_max = &cnt_value;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_READ;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    cnt_inc  = 1'b0;
    cnt_load = 1'b0;
    cnt_din  = '0;
    ack      = '0;
    rsp_cnt  = '0;
    rsp_ovf  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = gnt_idx;
          op_d    = op_t'(sel_op);
          data_d  = sel_data;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        case (op_q)
          OP_INC:   cnt_inc = !(SAT && cnt_max);
          OP_LOAD: begin
            cnt_load = 1'b1;
            cnt_din  = data_q;
          end
          OP_CLEAR: cnt_load = 1'b1;
          default:  ;  // READ and anything unexpected: no counter action
        endcase
        // Overflow is flagged whether the INC wraps or is held at max.
        ovf_d   = (op_q == OP_INC) && cnt_max;
        state_d = S_RESP;
      end

      S_RESP: begin
        ack[win_q] = 1'b1;
        rsp_cnt    = cnt_value;  // already reflects the ISSUE-cycle update
        rsp_ovf    = ovf_q;
        ptr_d      = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack     = ack;
  assign bus.rsp_cnt = rsp_cnt;
  assign bus.rsp_ovf = rsp_ovf;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: two DUT pairs (wrap and saturate), each with its
// own up-counter, driven by the same requester stimulus. A transaction-level
// model checks every ack; directed calls pin literal response values.
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus0 ();
  counter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus1 ();

  logic         inc0, load0, inc1, load1;
  logic [W-1:0] din0, din1, val0, val1;

  counter_arbiter #(.N_REQ(N), .WIDTH(W), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .cnt_inc(inc0), .cnt_load(load0), .cnt_din(din0), .cnt_value(val0)
  );

  counter_arbiter #(.N_REQ(N), .WIDTH(W), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .cnt_inc(inc1), .cnt_load(load1), .cnt_din(din1), .cnt_value(val1)
  );

  // The shared counters, reset by the system reset.
  always_ff @(posedge clk) begin
    if (rst)        val0 <= '0;
    else if (load0) val0 <= din0;
    else if (inc0)  val0 <= val0 + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)        val1 <= '0;
    else if (load1) val1 <= din1;
    else if (inc1)  val1 <= val1 + 8'd1;
  end

  // Per-requester drive variables, packed onto both buses.
  logic         tb_req  [N];
  logic [1:0]   tb_op   [N];
  logic [W-1:0] tb_data [N];
  logic [N-1:0]   req_vec;
  logic [2*N-1:0] op_vec;
  logic [W*N-1:0] data_vec;

  always_comb begin
    req_vec  = '0;
    op_vec   = '0;
    data_vec = '0;
    for (int i = 0; i < N; i++) begin
      req_vec[i]        = tb_req[i];
      op_vec[2*i +: 2]  = tb_op[i];
      data_vec[W*i +: W] = tb_data[i];
    end
  end

  assign bus0.req = req_vec;  assign bus0.req_op = op_vec;  assign bus0.req_data = data_vec;
  assign bus1.req = req_vec;  assign bus1.req_op = op_vec;  assign bus1.req_data = data_vec;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit             v;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] data;
    logic           busy;
    logic           inc;
    logic           load;
    logic [W-1:0]   din;
    logic [N-1:0]   ack;
    logic [W-1:0]   cnt;
    logic           ovf;
  } samp_t;

  samp_t h1 [2];  // previous cycle
  samp_t h2 [2];  // two cycles ago
  int    m_cnt [2] = '{0, 0};
  int    m_ptr [2] = '{0, 0};
  int    ack_cnt0 = 0;

  function automatic samp_t sample(input int k);
    samp_t s;
    s.v   = 1'b1;
    s.rst = rst;
    if (k == 0) begin
      s.req = bus0.req; s.op = bus0.req_op; s.data = bus0.req_data; s.busy = bus0.busy;
      s.inc = inc0; s.load = load0; s.din = din0;
      s.ack = bus0.ack; s.cnt = bus0.rsp_cnt; s.ovf = bus0.rsp_ovf;
    end else begin
      s.req = bus1.req; s.op = bus1.req_op; s.data = bus1.req_data; s.busy = bus1.busy;
      s.inc = inc1; s.load = load1; s.din = din1;
      s.ack = bus1.ack; s.cnt = bus1.rsp_cnt; s.ovf = bus1.rsp_ovf;
    end
    return s;
  endfunction

  // An ack in cycle t completes the request granted in the idle cycle t-2;
  // the counter strobes belong to cycle t-1.
  task automatic model_step(input int k, inout samp_t c);
    bit sat;
    int w, op, data, nc, ovf, e_inc, e_load, idx;
    sat = (k == 1);
    if (c.rst) begin
      m_cnt[k] = 0;
      m_ptr[k] = 0;
      c.v      = 1'b0;
      return;
    end
    check($sformatf("inc_load_excl_%0d", k), 32'(c.inc & c.load), 0);
    if (h1[k].v && (h1[k].inc || h1[k].load))
      check($sformatf("strobe_then_ack_%0d", k), 32'(c.ack != '0), 1);
    if (c.ack == '0) return;
    if (k == 0) ack_cnt0++;
    if (!h1[k].v || !h2[k].v) begin
      check($sformatf("ack_history_%0d", k), 0, 1);
      return;
    end
    w = -1;
    for (int off = 0; off < N; off++) begin
      idx = (m_ptr[k] + off) % N;
      if (w < 0 && h2[k].req[idx]) w = idx;
    end
    if (w < 0) begin
      check($sformatf("ack_without_req_%0d", k), 32'(c.ack), 0);
      return;
    end
    op     = int'(h2[k].op[2*w +: 2]);
    data   = int'(h2[k].data[W*w +: W]);
    nc     = m_cnt[k];
    ovf    = 0;
    e_inc  = 0;
    e_load = 0;
    case (op)
      0: begin
        if (m_cnt[k] == 255) begin
          ovf   = 1;
          nc    = sat ? 255 : 0;
          e_inc = sat ? 0 : 1;
        end else begin
          nc    = m_cnt[k] + 1;
          e_inc = 1;
        end
      end
      1: begin nc = data; e_load = 1; end
      2: begin nc = 0;    e_load = 1; end
      default: ;
    endcase
    check($sformatf("ack_vec_%0d", k),     32'(c.ack), 32'(1 << w));
    check($sformatf("busy_grant_%0d", k),  32'(h2[k].busy), 0);
    check($sformatf("busy_issue_%0d", k),  32'(h1[k].busy), 1);
    check($sformatf("busy_resp_%0d", k),   32'(c.busy), 1);
    check($sformatf("strobe_inc_%0d", k),  32'(h1[k].inc), e_inc);
    check($sformatf("strobe_load_%0d", k), 32'(h1[k].load), e_load);
    if (e_load != 0) check($sformatf("cnt_din_%0d", k), 32'(h1[k].din), nc);
    check($sformatf("rsp_cnt_%0d", k),     32'(c.cnt), nc);
    check($sformatf("rsp_ovf_%0d", k),     32'(c.ovf), ovf);
    m_cnt[k] = nc;
    m_ptr[k] = (w + 1) % N;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      samp_t c;
      c = sample(k);
      model_step(k, c);
      h2[k] = h1[k];
      h1[k] = c;
    end
  end

  // ------------------------------------------------------------- stimulus
  // Called just after a rising edge; returns just after the edge that ends
  // the ack cycle, having dropped req unless keep is set.
  task automatic do_req(input int i, input int op, input int data, input bit keep,
                        output int c0, output int c1, output int o0, output int o1,
                        output time at);
    bit got;
    got = 1'b0;
    c0 = -1; c1 = -1; o0 = -1; o1 = -1; at = 0;
    tb_req[i]  = 1'b1;
    tb_op[i]   = op[1:0];
    tb_data[i] = data[W-1:0];
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus0.ack[i]) begin
        got = 1'b1;
        c0 = int'(bus0.rsp_cnt); o0 = int'(bus0.rsp_ovf);
        c1 = int'(bus1.rsp_cnt); o1 = int'(bus1.rsp_ovf);
        at = $time;
        check($sformatf("ack_pair_r%0d", i), 32'(bus1.ack[i]), 1);
      end
    end
    check($sformatf("ack_wait_r%0d", i), 32'(got), 1);
    @(posedge clk);
    #1;
    if (!keep) tb_req[i] = 1'b0;
  endtask

  task automatic req_chk(input string name, input int i, input int op, input int data,
                         input bit keep, input int e0, input int eo0, input int e1,
                         input int eo1, output time at);
    int c0, c1, o0, o1;
    do_req(i, op, data, keep, c0, c1, o0, o1, at);
    check({name, "_cnt0"}, c0, e0);
    check({name, "_ovf0"}, o0, eo0);
    check({name, "_cnt1"}, c1, e1);
    check({name, "_ovf1"}, o1, eo1);
  endtask

  task automatic run_inc(input int i);
    time t;
    for (int k = 0; k < 2; k++)
      req_chk($sformatf("rr_inc_r%0d_%0d", i, k), i, int'(OP_INC), 0, k < 1,
              8'h11 + i + 4*k, 0, 8'h11 + i + 4*k, 0, t);
  endtask

  initial begin
    time ta, tb;
    bit  seen;
    int  acks_before;
    for (int i = 0; i < N; i++) begin
      tb_req[i] = 1'b0; tb_op[i] = '0; tb_data[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",     32'(bus0.ack), 0);
    check("rst_rsp_cnt", 32'(bus0.rsp_cnt), 0);
    check("rst_rsp_ovf", 32'(bus0.rsp_ovf), 0);
    check("rst_busy",    32'(bus0.busy), 0);
    check("rst_inc",     32'(inc0), 0);
    check("rst_load",    32'(load0), 0);
    check("rst_din",     32'(din0), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single INC from count 0
    req_chk("inc_first", 0, int'(OP_INC), 0, 1'b0, 8'h01, 0, 8'h01, 0, ta);

    // LOAD then READ
    req_chk("load_a5", 2, int'(OP_LOAD), 8'hA5, 1'b0, 8'hA5, 0, 8'hA5, 0, ta);
    req_chk("read_a5", 1, int'(OP_READ), 8'h00, 1'b0, 8'hA5, 0, 8'hA5, 0, ta);

    // Preset 0x10 from requester 3 (pointer wraps to 0), then all four INC
    req_chk("load_10", 3, int'(OP_LOAD), 8'h10, 1'b0, 8'h10, 0, 8'h10, 0, ta);
    fork
      run_inc(0);
      run_inc(1);
      run_inc(2);
      run_inc(3);
    join

    // INC at all-ones: wraps on dut0, holds on dut1
    req_chk("load_ff", 0, int'(OP_LOAD), 8'hFF, 1'b0, 8'hFF, 0, 8'hFF, 0, ta);
    req_chk("inc_max", 1, int'(OP_INC),  8'h00, 1'b0, 8'h00, 1, 8'hFF, 1, ta);

    // CLEAR from requester 3, then pointer must favour requester 0
    req_chk("load_33", 2, int'(OP_LOAD),  8'h33, 1'b0, 8'h33, 0, 8'h33, 0, ta);
    req_chk("clear",   3, int'(OP_CLEAR), 8'h5A, 1'b0, 8'h00, 0, 8'h00, 0, ta);
    fork
      req_chk("wrap_r0", 0, int'(OP_READ), 0, 1'b0, 0, 0, 0, 0, ta);
      req_chk("wrap_r1", 1, int'(OP_READ), 0, 1'b0, 0, 0, 0, 0, tb);
    join
    check("wrap_order", 32'(ta < tb), 1);

    // Reset during ISSUE of an INC from requester 1 (pointer is 2 here)
    tb_req[1] = 1'b1; tb_op[1] = 2'(OP_INC); tb_data[1] = '0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = inc0;
    end
    check("mid_issue_seen", 32'(seen), 1);
    acks_before = ack_cnt0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ack",     32'(bus0.ack), 0);
    check("mid_rst_busy",    32'(bus0.busy), 0);
    check("mid_rst_inc",     32'(inc0), 0);
    check("mid_rst_load",    32'(load0), 0);
    check("mid_rst_rsp_cnt", 32'(bus0.rsp_cnt), 0);
    check("mid_rst_counter", 32'(val0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tb_req[3] = 1'b1; tb_op[3] = 2'(OP_READ); tb_data[3] = '0;
    fork
      req_chk("re_inc",  1, int'(OP_INC),  0, 1'b0, 8'h01, 0, 8'h01, 0, ta);
      req_chk("re_read", 3, int'(OP_READ), 0, 1'b0, 8'h01, 0, 8'h01, 0, tb);
    join
    check("ptr_reset_order", 32'(ta < tb), 1);
    check("no_aborted_ack",  ack_cnt0, acks_before + 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
